// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction issue sequencer: opcodes, IR field
// positions and the sequencer state encoding.
package isa_pkg;

  localparam int IR_W = 32;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_ROR     = 5'd5;
  localparam logic [4:0] OP_RAND    = 5'd6;
  localparam logic [4:0] OP_RXOR    = 5'd7;
  localparam logic [4:0] OP_RXNOR   = 5'd8;
  localparam logic [4:0] OP_RNAND   = 5'd9;
  localparam logic [4:0] OP_RNOR    = 5'd10;
  localparam logic [4:0] OP_RNOT    = 5'd11;
  localparam logic [4:0] OP_HALT    = 5'd31;

  localparam int OPER_MSB     = 31;
  localparam int OPER_LSB     = 27;
  localparam int RDST_MSB     = 26;
  localparam int RDST_LSB     = 22;
  localparam int RSRC1_MSB    = 21;
  localparam int RSRC1_LSB    = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_MSB    = 15;
  localparam int RSRC2_LSB    = 11;
  localparam int IMM_MSB      = 15;
  localparam int IMM_LSB      = 0;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  // Codes above the executable set but below HALT are reserved.
  function automatic logic is_illegal_op(input logic [4:0] op);
    return (op > OP_RNOT) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/instr_issue_mem.sv
// Program memory: synchronous-read RAM, write-first when the write and read
// addresses collide. Contents have no reset.
module instr_issue_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_issue_seq.sv
// Instruction issue sequencer: walks the program memory from 0 and presents each
// word on a valid/ready IR port. Optional macro: INSTR_ISSUE_ILLEGAL_TRAP_EN.
module instr_issue_seq
  import isa_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PROG_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(PROG_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              mem_we;
  logic [4:0]        oper;

  assign mem_we = load_en && ((state == IDLE) || (state == DONE)) &&
                  ({1'b0, load_addr} < DEPTH_X);
  assign oper   = rd_data[OPER_MSB:OPER_LSB];

  // The read address runs one step ahead so the word is ready when FETCH examines it.
  always_comb begin
    rd_addr = '0;
    case (state)
      FETCH:   rd_addr = pc;
      ISSUE:   rd_addr = (pc == LAST_PC) ? pc : pc + PC_ONE;
      default: rd_addr = '0;
    endcase
  end

  instr_issue_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (PROG_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef INSTR_ISSUE_ILLEGAL_TRAP_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir_out   <= '0;
      ir_valid <= 1'b0;
`ifdef INSTR_ISSUE_ILLEGAL_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= FETCH;
            pc    <= '0;
`ifdef INSTR_ISSUE_ILLEGAL_TRAP_EN
            err_q <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (oper == OP_HALT) begin
            state <= DONE;
`ifdef INSTR_ISSUE_ILLEGAL_TRAP_EN
          end else if (is_illegal_op(oper)) begin
            state <= DONE;
            err_q <= 1'b1;
`endif
          end else begin
            ir_out   <= rd_data;
            ir_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            if (pc == LAST_PC) begin
              state <= DONE;
            end else begin
              pc    <= pc + PC_ONE;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pc_out = pc;
  assign busy   = (state == FETCH) || (state == ISSUE);
  assign done   = (state == DONE);

endmodule
